// File: rtl/imm_ext_pkg.sv
// Shared encodings and field widths for the immediate-extension pipeline.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        LEN5    = 2'b00,
        LEN8    = 2'b01,
        LEN11   = 2'b10,
        LEN_ILL = 2'b11
    } imm_len_e;

    localparam int LEN5_W  = 5;
    localparam int LEN8_W  = 8;
    localparam int LEN11_W = 11;

    // Field width for an encoding; zero for the illegal code.
    function automatic logic [3:0] len_width(input imm_len_e len);
        case (len)
            LEN5:    len_width = 4'(LEN5_W);
            LEN8:    len_width = 4'(LEN8_W);
            LEN11:   len_width = 4'(LEN11_W);
            default: len_width = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational sign/zero extension of a 5/8/11-bit immediate field to OUT_W bits.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       imm_len,
    input  logic             imm_sign,
    output logic [OUT_W-1:0] value,
    output logic             err
);

    // Working width covers both the widest field and the output.
    localparam int PAD_W = (OUT_W > LEN11_W) ? OUT_W : LEN11_W;

    imm_len_e         w_len;
    logic [PAD_W-1:0] w_pad;
    logic [PAD_W-1:0] w_mask;
    logic [PAD_W-1:0] w_ext;
    logic [3:0]       w_n;
    logic             w_top;

    assign w_len = imm_len_e'(imm_len);
    assign w_pad = PAD_W'(data_in);
    assign w_n   = len_width(w_len);

    always_comb begin
        w_top = 1'b0;
        case (w_len)
            LEN5:    w_top = w_pad[LEN5_W-1];
            LEN8:    w_top = w_pad[LEN8_W-1];
            LEN11:   w_top = w_pad[LEN11_W-1];
            default: w_top = 1'b0;
        endcase
    end

    always_comb begin
        w_mask = {PAD_W{1'b1}} << w_n;
        w_ext  = (w_pad & ~w_mask) | ((imm_sign && w_top) ? w_mask : '0);
        err    = (w_len == LEN_ILL);
        value  = err ? '0 : w_ext[OUT_W-1:0];
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a two-entry skid FIFO; values are extended before storage.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       imm_len,
    input  logic             imm_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extended_data,
    output logic             imm_err
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [OUT_W-1:0] r_val [2];
    logic             r_err [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic [OUT_W-1:0] w_val;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data_in  (data_in),
        .imm_len  (imm_len),
        .imm_sign (imm_sign),
        .value    (w_val),
        .err      (w_err)
    );

    // in_ready is a pure function of registered count, so out_ready never reaches it.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Gate by out_valid so reset and empty states present zero.
    assign extended_data = out_valid ? r_val[r_rptr] : '0;
    assign imm_err       = out_valid ? r_err[r_rptr] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val[0] <= '0;
            r_val[1] <= '0;
            r_err[0] <= 1'b0;
            r_err[1] <= 1'b0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_val[r_wptr] <= w_val;
                r_err[r_wptr] <= w_err;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed steps plus a short random burst.
module tb_imm_extend_pipe;

    localparam int IN_W  = 11;
    localparam int OUT_W = 16;

    typedef struct packed {
        logic [OUT_W-1:0] v;
        logic             e;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             imm_sign = 1'b0;
    logic [IN_W-1:0]  data_in = '0;
    logic [1:0]       imm_len = 2'b00;
    logic             in_ready;
    logic             out_valid;
    logic             imm_err;
    logic [OUT_W-1:0] extended_data;

    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_deliv = 0;
    int   mc      = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .imm_len       (imm_len),
        .imm_sign      (imm_sign),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .extended_data (extended_data),
        .imm_err       (imm_err)
    );

    // Reference: take the field modulo 2^n, then subtract 2^n when negative.
    function automatic exp_t ref_ext(input logic [IN_W-1:0] d, input logic [1:0] len, input logic s);
        int          n;
        int unsigned low;
        exp_t        r;
        case (len)
            2'b00:   n = 5;
            2'b01:   n = 8;
            2'b10:   n = 11;
            default: n = 0;
        endcase
        if (n == 0) begin
            r.v = '0;
            r.e = 1'b1;
        end else begin
            low = int'(d) % (1 << n);
            if (s && low >= (1 << (n - 1)))
                low = low + (1 << OUT_W) - (1 << n);
            r.v = OUT_W'(low);
            r.e = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic [1:0] l, input logic s);
        in_valid = v;
        data_in  = d;
        imm_len  = l;
        imm_sign = s;
    endtask

    // Monitor on the falling edge: check head against scoreboard, then advance the model.
    always @(negedge clk) begin
        exp_t h;
        if (!rst_n) begin
            sb.delete();
            mc = 0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_data", 32'(extended_data), 32'd0);
            chk("rst_err", 32'(imm_err), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(mc != 2));
            chk("out_valid", 32'(out_valid), 32'(mc != 0));
            if (mc != 0) begin
                h = sb[0];
                chk("head_data", 32'(extended_data), 32'(h.v));
                chk("head_err", 32'(imm_err), 32'(h.e));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (mc != 0 && out_ready) begin
                    void'(sb.pop_front());
                    n_deliv++;
                end
                if (in_valid && mc != 2)
                    sb.push_back(ref_ext(data_in, imm_len, imm_sign));
            end
            mc = sb.size();
        end
    end

    initial begin
        int d0;
        int k;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after release accepts a push; 5-bit signed all-ones.
        out_ready = 1'b1;
        drive(1'b1, 11'h01F, 2'b00, 1'b1);
        tick();
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("r034_data", 32'(extended_data), 32'hFFFF);
        chk("r034_err", 32'(imm_err), 32'd0);
        chk("r034_valid", 32'(out_valid), 32'd1);
        tick();
        chk("r034_one_cycle", 32'(out_valid), 32'd0);

        drive(1'b1, 11'h080, 2'b01, 1'b1);
        tick();
        chk("r035_signed", 32'(extended_data), 32'hFF80);
        drive(1'b1, 11'h080, 2'b01, 1'b0);
        tick();
        chk("r035_zero", 32'(extended_data), 32'h0080);
        drive(1'b0, '0, 2'b00, 1'b0);
        tick();

        drive(1'b1, 11'h400, 2'b10, 1'b1);
        tick();
        chk("r036_len11", 32'(extended_data), 32'hFC00);
        drive(1'b1, 11'h400, 2'b11, 1'b1);
        tick();
        chk("r036_ill_data", 32'(extended_data), 32'h0000);
        chk("r036_ill_err", 32'(imm_err), 32'd1);
        drive(1'b0, '0, 2'b00, 1'b0);
        tick();

        // Backpressure: fill both entries, then drain in order.
        out_ready = 1'b0;
        d0 = n_deliv;
        drive(1'b1, 11'h005, 2'b00, 1'b0);
        tick();
        chk("r037_ready_one", 32'(in_ready), 32'd1);
        drive(1'b1, 11'h006, 2'b00, 1'b0);
        tick();
        chk("r037_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, 11'h007, 2'b00, 1'b0);
        tick();
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("r037_hold", 32'(extended_data), 32'h0005);
        out_ready = 1'b1;
        tick();
        chk("r037_second", 32'(extended_data), 32'h0006);
        chk("r037_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("r037_empty", 32'(out_valid), 32'd0);
        chk("r037_count", 32'(n_deliv - d0), 32'd2);

        // Flush while full with a field offered.
        out_ready = 1'b0;
        drive(1'b1, 11'h011, 2'b01, 1'b0);
        tick();
        drive(1'b1, 11'h012, 2'b01, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 11'h3FF, 2'b10, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("r038_valid", 32'(out_valid), 32'd0);
        chk("r038_ready", 32'(in_ready), 32'd1);
        tick();
        chk("r038_dropped", 32'(out_valid), 32'd0);

        // Flush with one entry and an acceptable offer: the offer is still dropped.
        drive(1'b1, 11'h021, 2'b00, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 11'h022, 2'b00, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("flush1_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("empty_pop_ignored", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with one entry held.
        out_ready = 1'b0;
        drive(1'b1, 11'h00A, 2'b00, 1'b0);
        tick();
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("r039_before", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r039_async_valid", 32'(out_valid), 32'd0);
        chk("r039_async_ready", 32'(in_ready), 32'd1);
        chk("r039_async_data", 32'(extended_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("r039_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 11'h0AA, 2'b01, 1'b0);
        tick();
        drive(1'b0, '0, 2'b00, 1'b0);
        chk("r039_recover", 32'(extended_data), 32'h00AA);
        tick();

        // Random burst checked by the monitor.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 11'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        drive(1'b0, '0, 2'b00, 1'b0);
        flush     = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        tick();
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
